// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
//   - LoongArch32 major-opcode constants (inst[31:26]) used by decode
//   - reset value of the 2-bit direction counters (weakly not-taken)
//   - WORD: datapath width
//   - br_class_e / decode_op: classify a fetched instruction
package branch_predictor_pkg;

    localparam int WORD = 32;

    localparam logic [5:0] OP_B    = 6'b010100;
    localparam logic [5:0] OP_BL   = 6'b010101;
    localparam logic [5:0] OP_JIRL = 6'b010011;
    localparam logic [5:0] COND_LO = 6'b010110;   // BEQ
    localparam logic [5:0] COND_HI = 6'b011011;   // BGEU

    localparam logic [1:0] CTR_RST = 2'b01;

    typedef enum logic [1:0] {
        BR_NONE,
        BR_DIRECT,
        BR_COND,
        BR_JIRL
    } br_class_e;

    function automatic br_class_e decode_op(input logic [5:0] op);
        if (op == OP_B || op == OP_BL) begin
            return BR_DIRECT;
        end else if (op == OP_JIRL) begin
            return BR_JIRL;
        end else if (op >= COND_LO && op <= COND_HI) begin
            return BR_COND;
        end else begin
            return BR_NONE;
        end
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, one BHT entry.
// Ports:
//   clk   - core clock
//   rstn  - asynchronous active-low reset, loads RST_VAL
//   en    - step the counter this cycle
//   up    - 1: increment (saturate at 2'b11), 0: decrement (saturate at 2'b00)
//   cnt   - current counter value
module sat_counter2
    import branch_predictor_pkg::*;
#(
    parameter logic [1:0] RST_VAL = CTR_RST
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       up,
    output logic [1:0] cnt
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= RST_VAL;
        end else if (en) begin
            if (up) begin
                if (cnt != 2'b11) cnt <= cnt + 2'd1;
            end else begin
                if (cnt != 2'b00) cnt <= cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor for the LoongArch32 core.
// Decodes the fetched instruction and produces a same-cycle taken/target
// prediction; tables are trained from the execute-stage resolution port.
//   B/BL        : always taken, PC + sext({inst[9:0],inst[25:10],2'b00})
//   conditional : taken iff BHT counter MSB is set, PC + sext({inst[25:10],2'b00})
//   JIRL        : BTB hit -> taken to stored target, otherwise PC+4
//   other       : not taken, PC+4
// Optional feature macro: BRANCH_PRED_BTB_EN enables the JIRL target buffer.
// Without it JIRL is always predicted not taken and JIRL updates are dropped.
// Ports:
//   clk, rstn                 - clock, asynchronous active-low reset
//   PC, ICache_ready, inst    - fetch lookup inputs
//   pre_taken, pre_pc         - combinational prediction
//   upd_valid, upd_pc, upd_is_cond, upd_is_jirl, upd_taken, upd_target
//                             - resolution/training port, written at clk edge
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int BHT_IDX_W = 6,
    parameter int BTB_IDX_W = 4,
    parameter int BTB_TAG_W = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [WORD-1:0] PC,
    input  logic            ICache_ready,
    input  logic [WORD-1:0] inst,
    output logic            pre_taken,
    output logic [WORD-1:0] pre_pc,
    input  logic            upd_valid,
    input  logic [WORD-1:0] upd_pc,
    input  logic            upd_is_cond,
    input  logic            upd_is_jirl,
    input  logic            upd_taken,
    input  logic [WORD-1:0] upd_target
);

    localparam int BHT_N = 1 << BHT_IDX_W;

    // ---------------------------------------------------------------
    // Direction table
    // ---------------------------------------------------------------
    logic [1:0]           bht_cnt [BHT_N];
    logic [BHT_IDX_W-1:0] bht_lk_idx;
    logic [BHT_IDX_W-1:0] bht_upd_idx;
    logic                 bht_upd;

    assign bht_lk_idx  = PC[BHT_IDX_W+1:2];
    assign bht_upd_idx = upd_pc[BHT_IDX_W+1:2];
    assign bht_upd     = upd_valid && upd_is_cond;

    for (genvar g = 0; g < BHT_N; g++) begin : g_bht
        sat_counter2 #(
            .RST_VAL (CTR_RST)
        ) u_ctr (
            .clk  (clk),
            .rstn (rstn),
            .en   (bht_upd && (bht_upd_idx == BHT_IDX_W'(g))),
            .up   (upd_taken),
            .cnt  (bht_cnt[g])
        );
    end

    // ---------------------------------------------------------------
    // JIRL target buffer
    // ---------------------------------------------------------------
`ifdef BRANCH_PRED_BTB_EN
    localparam int BTB_N = 1 << BTB_IDX_W;

    logic                 btb_valid [BTB_N];
    logic [BTB_TAG_W-1:0] btb_tag   [BTB_N];
    logic [WORD-3:0]      btb_tgt   [BTB_N];

    logic [BTB_IDX_W-1:0] btb_lk_idx;
    logic [BTB_TAG_W-1:0] btb_lk_tag;
    logic [BTB_IDX_W-1:0] btb_upd_idx;
    logic [BTB_TAG_W-1:0] btb_upd_tag;
    logic                 btb_hit;

    assign btb_lk_idx  = PC[BTB_IDX_W+1:2];
    assign btb_lk_tag  = PC[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
    assign btb_upd_idx = upd_pc[BTB_IDX_W+1:2];
    assign btb_upd_tag = upd_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
    assign btb_hit     = btb_valid[btb_lk_idx] && (btb_tag[btb_lk_idx] == btb_lk_tag);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid[i] <= 1'b0;
                btb_tag[i]   <= '0;
                btb_tgt[i]   <= '0;
            end
        end else if (upd_valid && upd_is_jirl && upd_taken) begin
            btb_valid[btb_upd_idx] <= 1'b1;
            btb_tag[btb_upd_idx]   <= btb_upd_tag;
            btb_tgt[btb_upd_idx]   <= upd_target[WORD-1:2];
        end
    end
`endif

    // Not every address bit feeds an index or tag, and the BTB port and
    // parameters are dead when the buffer is compiled out.
    logic unused_bits;
    assign unused_bits = ^{PC, upd_pc, upd_target, upd_is_jirl, 32'(BTB_IDX_W + BTB_TAG_W)};

    // ---------------------------------------------------------------
    // Decode and prediction
    // ---------------------------------------------------------------
    br_class_e       cls;
    logic [WORD-1:0] offs_direct;
    logic [WORD-1:0] offs_cond;
    logic [WORD-1:0] pc_plus4;

    assign cls         = decode_op(inst[31:26]);
    assign offs_direct = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    assign offs_cond   = {{14{inst[25]}}, inst[25:10], 2'b00};
    assign pc_plus4    = PC + 32'd4;

    // Gated by rstn so nothing is predicted taken while the core is held in reset.
    always_comb begin
        pre_taken = 1'b0;
        pre_pc    = pc_plus4;
        if (rstn && ICache_ready) begin
            case (cls)
                BR_DIRECT: begin
                    pre_taken = 1'b1;
                    pre_pc    = PC + offs_direct;
                end
                BR_COND: begin
                    if (bht_cnt[bht_lk_idx][1]) begin
                        pre_taken = 1'b1;
                        pre_pc    = PC + offs_cond;
                    end
                end
`ifdef BRANCH_PRED_BTB_EN
                BR_JIRL: begin
                    if (btb_hit) begin
                        pre_taken = 1'b1;
                        pre_pc    = {btb_tgt[btb_lk_idx], 2'b00};
                    end
                end
`endif
                default: begin
                    pre_taken = 1'b0;
                    pre_pc    = pc_plus4;
                end
            endcase
        end
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised fetch-stage branch predictor for the LoongArch32 core, replacing the static "always-taken direct branch" scheme. It decodes the fetched instruction, indexes a table of 2-bit saturating counters for conditional branches, and optionally a small direct-mapped target buffer for JIRL. It produces a taken/target prediction in the same cycle the ICache returns the instruction. The tables are trained one cycle later from the execute-stage resolution port.

## Interface
- `BHT_IDX_W`, default 6: counter table has 2^BHT_IDX_W entries, indexed by `PC[BHT_IDX_W+1:2]`.
- `BTB_IDX_W`, default 4: JIRL target buffer has 2^BTB_IDX_W entries, indexed by `PC[BTB_IDX_W+1:2]`.
- `BTB_TAG_W`, default 8: tag is `PC[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2]`.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `rstn`  in  1  asynchronous, active-low reset.
- `PC`  in  32  fetch PC of `inst`.
- `ICache_ready`  in  1  `inst` is valid this cycle.
- `inst`  in  32  fetched instruction.
- `pre_taken`  out  1  predicted taken.
- `pre_pc`  out  32  predicted next PC.
- `upd_valid`  in  1  a resolved branch is presented this cycle.
- `upd_pc`  in  32  PC of the resolved branch.
- `upd_is_cond`  in  1  resolved instruction is BEQ/BNE/BLT/BGE/BLTU/BGEU.
- `upd_is_jirl`  in  1  resolved instruction is JIRL.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  32  actual target.

## Operation
- Decode on `inst[31:26]`:
  - B = 010100, BL = 010101.
  - JIRL = 010011.
  - Conditional = 010110..011011.
  - Anything else is a non-branch.
- Offsets:
  - B/BL: `sext({inst[9:0],inst[25:10],2'b00})`.
  - Conditional: `sext({inst[25:10],2'b00})`.
  - All sums are mod 2^32.
- Prediction is combinational and only valid when `ICache_ready`=1. If `ICache_ready`=0, then `pre_taken`=0 and `pre_pc`=PC+4.
  - B/BL: taken, target PC+offs.
  - Conditional: taken iff `bht[idx][1]`=1; target PC+offs if taken, else PC+4.
  - JIRL: see Configuration.
  - Non-branch: not taken, PC+4.
- BHT training: on `upd_valid & upd_is_cond`, the counter at `upd_pc[BHT_IDX_W+1:2]` moves one step.
  - Increments if `upd_taken`, decrements otherwise.
  - Saturates at 2'b11 and 2'b00.
- Training with `upd_is_cond`=0 leaves the BHT unchanged.
- `upd_is_cond` and `upd_is_jirl` both high is illegal; the bench never drives it.

## Timing
- Lookup has zero-cycle latency: combinational from `PC`/`inst`/`ICache_ready`.
- Updates are written at the rising `clk` edge and are visible to lookups from the next cycle.
- A same-cycle lookup and update to the same index returns the old value. There is no bypass.
- Reset values:
  - All BHT counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0.
  - While `rstn`=0, `pre_taken`=0 and `pre_pc`=PC+4.
- Reset asserted mid-training discards any pending write. The next edge after release behaves normally.
- Every table bit is a flop with asynchronous reset. No RAM macro.

## Configuration
- `BRANCH_PRED_BTB_EN` defined:
  - Target buffer entries hold {valid, tag, target[31:2]}.
  - On `upd_valid & upd_is_jirl & upd_taken`, the entry at the BTB index is written with valid=1, tag, and `upd_target[31:2]`.
  - A JIRL lookup hit (valid & tag match) predicts taken with `pre_pc`={target,2'b00}.
  - A miss predicts not taken, PC+4.
- `BRANCH_PRED_BTB_EN` undefined:
  - No BTB storage; the `BTB_*` parameters are ignored.
  - JIRL is always predicted not taken with PC+4.
  - JIRL updates are ignored.

## Structure
- Shared package: opcode constants (OP_B, OP_BL, OP_JIRL, COND_LO, COND_HI), the 2-bit counter reset value, and a `WORD` = 32 constant.
- One sub-module, `sat_counter2`: a 2-bit saturating up/down counter with enable and asynchronous reset to a parameter value. It is instantiated 2^BHT_IDX_W times.
- Decode, offset generation and the BTB stay in the top level.

## Test plan
- Reset, then any conditional branch at PC=0x1C000000 with `ICache_ready`=1 → `pre_taken`=0, `pre_pc`=0x1C000004.
- B with inst=0x53FFFFFF (offset −4) at PC=0x1C000100 → `pre_taken`=1, `pre_pc`=0x1C0000FC. Same inst with `ICache_ready`=0 → `pre_taken`=0.
- BEQ at PC=0x1C000040 trained taken once (counter 01→10) → next-cycle lookup predicts taken. Three further not-taken updates → counter 00. A fourth not-taken update keeps it at 00 (saturation).
- Same-cycle update and lookup at the same index from counter 01, update taken → lookup returns not-taken; the following cycle returns taken.
- With `BRANCH_PRED_BTB_EN`: JIRL at PC=0x1C000080 trained with target 0x1C001000 → lookup gives taken, `pre_pc`=0x1C001000. A PC differing only in a tag bit misses → PC+4.
- Assert `rstn` low mid-stream after training → all counters return to 01, BTB invalid, and predictions revert to not-taken.
